// File: rtl/a2d_analog_model.sv
// Purpose : behavioural SPI-slave model of the 8-channel 12-bit A2D (pipelined command/response).
// Latency : channel requested in transaction N is returned in transaction N+1; MISO bits settle within 3 clk of SCLK rise.
// Backpressure: none; master must hold SCLK phases >= 4 clk and SS_n high >= 4 clk between words.
//
// Ports:
//   clk, rst_n         system clock / async active-low reset
//   SS_n, SCLK, MOSI   SPI master signals (asynchronous to clk, synchronised here)
//   MISO               serial response, forced 0 while deselected
//   BATT/CURR/BRAKE/TORQUE  12-bit analog values, sampled at SS_n fall
module a2d_analog_model #(
    parameter logic [2:0] BATT_CH   = 3'd0,
    parameter logic [2:0] CURR_CH   = 3'd1,
    parameter logic [2:0] BRAKE_CH  = 3'd3,
    parameter logic [2:0] TORQUE_CH = 3'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [11:0] BATT,
    input  logic [11:0] CURR,
    input  logic [11:0] BRAKE,
    input  logic [11:0] TORQUE
);

    // Two synchroniser flops per input plus a third for edge detection.
    logic        ss_ff1, ss_ff2, ss_ff3;
    logic        sclk_ff1, sclk_ff2, sclk_ff3;
    logic        mosi_ff1, mosi_ff2;

    logic [15:0] shft;
    logic [4:0]  bit_cnt;
    logic [2:0]  chnl;
    logic [11:0] sel_val;

    logic        ss_fall;
    logic        ss_rise;
    logic        sclk_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_ff1   <= 1'b1;
            ss_ff2   <= 1'b1;
            ss_ff3   <= 1'b1;
            sclk_ff1 <= 1'b1;
            sclk_ff2 <= 1'b1;
            sclk_ff3 <= 1'b1;
            mosi_ff1 <= 1'b0;
            mosi_ff2 <= 1'b0;
        end else begin
            ss_ff1   <= SS_n;
            ss_ff2   <= ss_ff1;
            ss_ff3   <= ss_ff2;
            sclk_ff1 <= SCLK;
            sclk_ff2 <= sclk_ff1;
            sclk_ff3 <= sclk_ff2;
            mosi_ff1 <= MOSI;
            mosi_ff2 <= mosi_ff1;
        end
    end

    assign ss_fall   =  ss_ff3 & ~ss_ff2;
    assign ss_rise   = ~ss_ff3 &  ss_ff2;
    assign sclk_rise = ~sclk_ff3 & sclk_ff2;

    // Response value for the channel latched by the previous transaction.
    always_comb begin
        sel_val = 12'h000;
        if (chnl == BATT_CH)        sel_val = BATT;
        else if (chnl == CURR_CH)   sel_val = CURR;
        else if (chnl == BRAKE_CH)  sel_val = BRAKE;
        else if (chnl == TORQUE_CH) sel_val = TORQUE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shft    <= 16'h0000;
            bit_cnt <= 5'd0;
            chnl    <= 3'd0;
        end else begin
            if (ss_fall) begin
                shft    <= {4'h0, sel_val};
                bit_cnt <= 5'd0;
            end else if (sclk_rise && !ss_ff2) begin
                shft <= {shft[14:0], mosi_ff2};
                if (bit_cnt != 5'd16)
                    bit_cnt <= bit_cnt + 5'd1;
            end
            // Only a complete 16-bit command updates the channel; aborted words are dropped.
            if (ss_rise && bit_cnt == 5'd16)
                chnl <= shft[13:11];
        end
    end

    // Gate on both ss_ff2 and ss_ff3 so the stale shft[15] from the previous word is
    // never driven during the single clk in which the new value is being loaded.
    assign MISO = ~ss_ff2 & ~ss_ff3 & shft[15];

endmodule

// File: tb/tb_a2d_analog_model.sv
// Purpose : randomized + directed bench for a2d_analog_model against a transaction-level model.
// Latency : bench master runs SCLK = clk/32, SS_n setup/hold 8 clk.
// Backpressure: none.
module tb_a2d_analog_model;

    logic        clk;
    logic        rst_n;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic [11:0] BATT;
    logic [11:0] CURR;
    logic [11:0] BRAKE;
    logic [11:0] TORQUE;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level model: the only state is the channel the next word will return.
    logic [2:0] model_chnl;

    a2d_analog_model dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .SS_n   (SS_n),
        .SCLK   (SCLK),
        .MOSI   (MOSI),
        .MISO   (MISO),
        .BATT   (BATT),
        .CURR   (CURR),
        .BRAKE  (BRAKE),
        .TORQUE (TORQUE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_value(input logic [2:0] ch);
        case (ch)
            3'd0:    return {4'h0, BATT};
            3'd1:    return {4'h0, CURR};
            3'd3:    return {4'h0, BRAKE};
            3'd4:    return {4'h0, TORQUE};
            default: return 16'h0000;
        endcase
    endfunction

    // One SCLK period: drive MOSI in the low phase, sample MISO just before the rise.
    task automatic send_bit(input logic b, output logic sampled);
        @(negedge clk);
        SCLK = 1'b0;
        MOSI = b;
        repeat (16) @(negedge clk);
        sampled = MISO;
        SCLK = 1'b1;
        repeat (15) @(negedge clk);
    endtask

    // Word sent MSB first; bits beyond 16 are zeros; only the first 16 MISO bits are captured.
    task automatic xfer(input logic [15:0] w, input int nbits, output logic [15:0] rx);
        logic s;
        rx = 16'h0000;
        @(negedge clk);
        SS_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            send_bit((i < 16) ? w[15-i] : 1'b0, s);
            if (i < 16) rx[15-i] = s;
        end
        repeat (8) @(negedge clk);
        SS_n = 1'b1;
        MOSI = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // Run a transaction, check the response against the model, then advance the model.
    task automatic run_chk(input string tag, input logic [15:0] w, input int nbits);
        logic [15:0] exp;
        logic [15:0] rx;
        logic [15:0] mask;
        logic [31:0] stream;
        logic [15:0] cmd;
        exp = model_value(model_chnl);
        xfer(w, nbits, rx);
        if (nbits >= 16) begin
            check(tag, rx, exp);
            // The command is whatever the last 16 bits clocked in were.
            stream = {16'h0000, w} << (nbits - 16);
            cmd = stream[15:0];
            model_chnl = cmd[13:11];
        end else if (nbits > 0) begin
            mask = 16'hFFFF << (16 - nbits);
            check(tag, rx & mask, exp & mask);
        end
    endtask

    logic [15:0] w_rand;
    int          nb;
    logic        dummy;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        SS_n   = 1'b1;
        SCLK   = 1'b1;
        MOSI   = 1'b0;
        BATT   = 12'hABC;
        CURR   = 12'h000;
        BRAKE  = 12'h000;
        TORQUE = 12'h000;
        model_chnl = 3'd0;
        repeat (4) @(negedge clk);
        check("reset_miso", {15'h0, MISO}, 16'h0000);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Reset / first read returns BATT.
        run_chk("first_batt", 16'h0000, 16);
        // Channel select.
        run_chk("sel_ch1", 16'h0800, 16);
        CURR = 12'h123;
        run_chk("read_curr", 16'h0800, 16);
        check("curr_val", model_value(3'd1), 16'h0123);
        run_chk("sel_ch3", 16'h1800, 16);
        BRAKE = 12'h3A5;
        run_chk("read_brake", 16'h0000, 16);
        // Full scale and unused channel.
        run_chk("sel_ch4", 16'h2000, 16);
        TORQUE = 12'hFFF;
        run_chk("read_torque", 16'h3800, 16);
        run_chk("read_ch7", 16'h0000, 16);

        // Sampling point: BATT changes mid-word, word in flight keeps the old value.
        BATT = 12'h555;
        fork
            run_chk("samp_old", 16'h0000, 16);
            begin
                repeat (8 + 64) @(negedge clk);
                BATT = 12'h2AA;
            end
        join
        run_chk("samp_new", 16'h0000, 16);

        // Aborted transaction keeps chnl=1.
        CURR = 12'h9C3;
        run_chk("sel_ch1b", 16'h0800, 16);
        run_chk("abort", 16'hFFFF, 8);
        run_chk("after_abort", 16'h0000, 16);

        // Extra SCLK edges: counter saturates, shifting continues.
        run_chk("extra_sel", 16'h0800, 18);
        run_chk("extra_read", 16'h0000, 16);

        // Mid-transaction reset with chnl=4 and TORQUE all ones on the wire.
        TORQUE = 12'hFFF;
        run_chk("pre_rst_a", 16'h2000, 16);
        run_chk("pre_rst_b", 16'h2000, 16);
        @(negedge clk);
        SS_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 6; i++) send_bit(1'b0, dummy);
        repeat (4) @(negedge clk);
        check("midword_miso", {15'h0, MISO}, 16'h0001);
        rst_n = 1'b0;
        #1;
        check("rst_miso", {15'h0, MISO}, 16'h0000);
        model_chnl = 3'd0;
        SS_n = 1'b1;
        SCLK = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        run_chk("post_rst_batt", 16'h0000, 16);

        // Randomized traffic.
        for (int t = 0; t < 24; t++) begin
            BATT   = 12'($urandom);
            CURR   = 12'($urandom);
            BRAKE  = 12'($urandom);
            TORQUE = 12'($urandom);
            w_rand = 16'($urandom);
            nb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 15)) : 16;
            run_chk("rand", w_rand, nb);
        end
        run_chk("rand_final", 16'h0000, 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
